// File: rtl/fcvt_s_w.sv
// fcvt_s_w: 3-stage RV32F integer (signed/unsigned) to binary32 converter, round-to-nearest-even
module fcvt_s_w (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_input,
    input  logic        is_signed,
    input  logic [31:0] a,
    output logic        valid_output,
    output logic [31:0] y,
    output logic        nx
);
    logic        v1, s1;
    logic [31:0] mag1;
    logic        v2, s2, z2;
    logic [31:0] norm2;
    logic [4:0]  e2;
    logic [4:0]  lz;
    logic [31:0] norm;
    logic [23:0] mant;
    logic        g, st, up;
    logic [24:0] sum;
    logic [7:0]  exp_b;
    logic [31:0] y_n;
    logic        nx_n;

    // S1: capture valid, sign and two's-complement magnitude
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            s1   <= 1'b0;
            mag1 <= 32'd0;
        end else begin
            v1   <= valid_input;
            s1   <= is_signed & a[31];
            mag1 <= (is_signed & a[31]) ? ~a + 32'd1 : a;
        end
    end

    // leading-zero count (highest set bit wins) and normalization shift
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 32; i++) lz = mag1[i] ? 5'(31 - i) : lz;
        norm = mag1 << lz;
    end

    // S2: register normalized mantissa, unbiased exponent and zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            s2    <= 1'b0;
            z2    <= 1'b0;
            norm2 <= 32'd0;
            e2    <= 5'd0;
        end else begin
            v2    <= v1;
            s2    <= s1;
            z2    <= mag1 == 32'd0;
            norm2 <= norm;
            e2    <= 5'd31 - lz;
        end
    end

    // RNE rounding at 25 bits; a carry-out leaves the fraction zero and bumps the exponent
    always_comb begin
        mant  = norm2[31:8];
        g     = norm2[7];
        st    = |norm2[6:0];
        up    = g & (st | mant[0]);
        sum   = {1'b0, mant} + {24'd0, up};
        exp_b = 8'd127 + {3'd0, e2} + {7'd0, sum[24]};
        y_n   = z2 ? 32'd0 : {s2, exp_b, sum[22:0]};
        nx_n  = g | st;
    end

    // S3: output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_output <= 1'b0;
            y            <= 32'd0;
            nx           <= 1'b0;
        end else begin
            valid_output <= v2;
            y            <= y_n;
            nx           <= nx_n;
        end
    end
endmodule

// File: tb/tb_fcvt_s_w.sv
// tb_fcvt_s_w: scoreboard bench for fcvt_s_w (directed spec vectors plus model-checked random operands)
module tb_fcvt_s_w;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_input = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = 32'd0;
    logic        valid_output;
    logic [31:0] y;
    logic        nx;

    typedef struct {
        logic [31:0] y;
        logic        nx;
        int          c;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    fcvt_s_w dut (
        .clk(clk),
        .rst(rst),
        .valid_input(valid_input),
        .is_signed(is_signed),
        .a(a),
        .valid_output(valid_output),
        .y(y),
        .nx(nx)
    );

    always #5 clk = ~clk;

    // cycle stamp used to check exact latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference: find MSB, then shift/round with explicit remainder comparison; returns {nx, y}
    function automatic logic [32:0] model(input logic sg, input logic [31:0] v);
        logic        s;
        logic [31:0] m;
        logic [63:0] qq, rem, half;
        int          p, sh, ex;
        logic        upr;
        s = sg & v[31];
        m = s ? (32'd0 - v) : v;
        if (m == 32'd0) return 33'd0;
        p = 31;
        while (!m[p]) p--;
        if (p <= 23) return {1'b0, s, 8'(127 + p), 23'({32'd0, m} << (23 - p))};
        sh   = p - 23;
        qq   = {32'd0, m} >> sh;
        rem  = {32'd0, m} & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        upr  = (rem > half) || (rem == half && qq[0]);
        qq   = qq + {63'd0, upr};
        ex   = 127 + p;
        if (qq[24]) begin
            qq = qq >> 1;
            ex++;
        end
        return {rem != 64'd0, s, 8'(ex), qq[22:0]};
    endfunction

    // drive inputs for the next edge; optionally push the expected result
    task automatic put(input logic v, input logic sg, input logic [31:0] val, input logic push, input logic [32:0] ex);
        exp_t t;
        valid_input = v;
        is_signed   = sg;
        a           = val;
        if (v && push) begin
            t.y  = ex[31:0];
            t.nx = ex[32];
            t.c  = cyc + 3;
            q.push_back(t);
        end
    endtask

    task automatic send(input logic v, input logic sg, input logic [31:0] val, input logic push, input logic [32:0] ex);
        @(posedge clk);
        #1;
        put(v, sg, val, push, ex);
    endtask

    task automatic send_m(input logic sg, input logic [31:0] val);
        send(1'b1, sg, val, 1'b1, model(sg, val));
    endtask

    // monitor: outputs must be idle in reset, otherwise compare against scoreboard head
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out", {31'd0, valid_output, nx, y}, 64'd0);
        end else if (valid_output) begin
            if (q.size() == 0) begin
                check("spurious", {32'd0, y}, 64'hdead);
            end else begin
                e = q.pop_front();
                check("y", {32'd0, y}, {32'd0, e.y});
                check("nx", {63'd0, nx}, {63'd0, e.nx});
                check("lat", 64'(cyc), 64'(e.c));
            end
        end
    end

    initial begin
        // reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            put(i[0], 1'b0, 32'h1234 + i, 1'b0, 33'd0);
        end
        send(1'b0, 1'b0, 0, 1'b0, 33'd0);
        rst = 1'b0;
        repeat (4) send(1'b0, 1'b0, 0, 1'b0, 33'd0);
        // exact back-to-back
        send(1'b1, 1'b0, 32'd1, 1'b1, {1'b0, 32'h3F800000});
        send(1'b1, 1'b0, 32'd2, 1'b1, {1'b0, 32'h40000000});
        send(1'b1, 1'b0, 32'd10, 1'b1, {1'b0, 32'h41200000});
        send(1'b1, 1'b0, 32'd0, 1'b1, {1'b0, 32'h00000000});
        // signed
        send(1'b1, 1'b1, 32'hFFFFFFCE, 1'b1, {1'b0, 32'hC2480000});
        send(1'b1, 1'b1, 32'h80000000, 1'b1, {1'b0, 32'hCF000000});
        send(1'b1, 1'b0, 32'h80000000, 1'b1, {1'b0, 32'h4F000000});
        send(1'b1, 1'b1, 32'd0, 1'b1, {1'b0, 32'h00000000});
        // rounding
        send(1'b1, 1'b0, 32'h01000001, 1'b1, {1'b1, 32'h4B800000});
        send(1'b1, 1'b0, 32'h01000003, 1'b1, {1'b1, 32'h4B800002});
        send(1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, {1'b1, 32'h4F800000});
        // bubbles 1,0,1
        send(1'b1, 1'b0, 32'd3, 1'b1, {1'b0, 32'h40400000});
        send(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 33'd0);
        send(1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, {1'b0, 32'hBF800000});
        // random operands with random bubbles
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) send(1'b0, 1'b0, $urandom, 1'b0, 33'd0);
            else send_m(1'(($urandom)), $urandom >> $urandom_range(0, 31));
        end
        repeat (4) send(1'b0, 1'b0, 0, 1'b0, 33'd0);
        // async reset while a result is on the output
        send(1'b1, 1'b0, 32'd7, 1'b1, {1'b0, 32'h40E00000});
        send(1'b0, 1'b0, 0, 1'b0, 33'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_drop", {63'd0, valid_output}, 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_drop", {63'd0, valid_output}, 64'd0);
        send(1'b0, 1'b0, 0, 1'b0, 33'd0);
        rst = 1'b0;
        // two operands in flight, reset one cycle later: both discarded
        send(1'b1, 1'b0, 32'd5, 1'b0, 33'd0);
        send(1'b1, 1'b0, 32'd6, 1'b0, 33'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid_input = 1'b0;
        send(1'b0, 1'b0, 0, 1'b0, 33'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        put(1'b1, 1'b0, 32'd1, 1'b1, {1'b0, 32'h3F800000});
        send(1'b0, 1'b0, 0, 1'b0, 33'd0);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("drain", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
